// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/gnt/rvalid data bus, store lane build, load align/extend, upstream stall.
// Optional: define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses without touching the bus.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_reg_write,
  input  logic [1:0]  ex_wb_sel,
  input  logic        ex_csr_hit,
  input  logic [31:0] ex_csr_data,
  output logic [31:0] mem_wb_candidate,
  output logic [31:0] mem_load_data,
  output logic [4:0]  mem_rd_addr,
  output logic        mem_reg_write,
  output logic [1:0]  mem_wb_sel,
  output logic        mem_csr_hit,
  output logic [31:0] mem_csr_data,
  output logic        mem_stall,
  output logic        mem_bus_err,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        mem_misalign,
`endif
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_ldbuf;
  logic          r_bus_err;

  logic          w_access, w_store, w_byte, w_half, w_misal, w_go;
  logic          w_req, w_stall, w_tmo, w_cnt_hit;
  logic [1:0]    w_off;
  logic [3:0]    w_be_st;
  logic [31:0]   w_wdata_st, w_shift, w_ld_aligned;

  assign w_off    = ex_alu_result[1:0];
  assign w_access = ex_valid & (ex_mem_read | ex_mem_write);
  // a read+write combination is resolved as a load
  assign w_store  = ex_mem_write & ~ex_mem_read;
  assign w_byte   = (ex_funct3[1:0] == 2'b00);
  assign w_half   = (ex_funct3[1:0] == 2'b01);

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misal  = w_access & ((w_half & w_off[0]) | (~w_byte & ~w_half & (w_off != 2'b00)));
`else
  assign w_misal  = 1'b0;
`endif
  assign w_go      = w_access & ~w_misal;
  assign w_cnt_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == LIM);

  always_comb begin
    w_be_st    = 4'b1111;
    w_wdata_st = ex_store_data;
    if (w_byte) begin
      w_be_st    = 4'b0001 << w_off;
      w_wdata_st = {4{ex_store_data[7:0]}};
    end else if (w_half) begin
      w_be_st    = 4'b0011 << {w_off[1], 1'b0};
      w_wdata_st = {2{ex_store_data[15:0]}};
    end
  end

  assign w_shift = dmem_rdata >> {w_off, 3'b000};

  always_comb begin
    case (ex_funct3)
      3'b000:  w_ld_aligned = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_ld_aligned = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_ld_aligned = {24'h0, w_shift[7:0]};
      3'b101:  w_ld_aligned = {16'h0, w_shift[15:0]};
      default: w_ld_aligned = dmem_rdata;
    endcase
  end

  always_comb begin
    w_next  = r_state;
    w_req   = 1'b0;
    w_stall = 1'b0;
    w_tmo   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_req   = 1'b1;
          w_stall = 1'b1;
          if (dmem_gnt) w_next = w_store ? S_DONE : S_RESP;
          else          w_next = S_REQ;
        end
      end
      S_REQ: begin
        w_req   = 1'b1;
        w_stall = 1'b1;
        if (dmem_gnt) w_next = w_store ? S_DONE : S_RESP;
        else if (w_cnt_hit) begin
          w_tmo  = 1'b1;
          w_next = S_DONE;
        end
      end
      S_RESP: begin
        w_stall = 1'b1;
        if (dmem_rvalid) w_next = S_DONE;
        else if (w_cnt_hit) begin
          w_tmo  = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ldbuf   <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_bus_err <= w_tmo;
      // counter restarts on every entry into a waiting state
      if ((w_next != r_state) && ((w_next == S_REQ) || (w_next == S_RESP)))
        r_cnt <= '0;
      else if ((r_state == S_REQ) || (r_state == S_RESP))
        r_cnt <= r_cnt + CW'(1);
      if (w_tmo)
        r_ldbuf <= '0;
      else if ((r_state == S_RESP) && dmem_rvalid)
        r_ldbuf <= w_ld_aligned;
    end
  end

  assign dmem_req   = w_req;
  assign dmem_we    = w_req & w_store;
  assign dmem_addr  = w_req ? {ex_alu_result[31:2], 2'b00} : 32'h0;
  assign dmem_be    = w_req ? (w_store ? w_be_st : 4'b1111) : 4'b0000;
  assign dmem_wdata = (w_req & w_store) ? w_wdata_st : 32'h0;

  assign mem_stall        = w_stall;
  assign mem_bus_err      = r_bus_err;
  assign mem_load_data    = r_ldbuf;
  assign mem_wb_candidate = ex_alu_result;
  assign mem_rd_addr      = ex_rd_addr;
  assign mem_wb_sel       = ex_wb_sel;
  assign mem_csr_hit      = ex_csr_hit;
  assign mem_csr_data     = ex_csr_data;
  assign mem_reg_write    = ex_reg_write & ex_valid & ~w_stall & ~w_misal;
`ifdef MEM_MISALIGN_TRAP_EN
  assign mem_misalign     = (r_state == S_IDLE) & w_misal;
`endif

endmodule
